dot_scan_ctrl: RTL and testbench

- Row-scan scheduler for the 8x16 LED dot matrix.
- Holds a double-buffered 8x16 frame image and steps through the 8 rows, one row period at a time.
- Inserts a blanking interval at the start of each row period to suppress ghosting.
- Swaps the display/back banks only at frame boundaries, so the key/position logic and animation writers can update the image without tearing.
- Sits between the frame producers and the row/col pins; replaces per-pattern scan case logic.

---
 rtl/dot_scan_ctrl_pkg.sv | 20 ++
 rtl/dot_frame_buf.sv | 33 +++
 rtl/dot_scan_ctrl.sv | 111 +++++++++++
 tb/tb_dot_scan_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_scan_ctrl_pkg.sv
// Shared constants, scan state encoding and row-select helper for the
// 8x16 dot-matrix row scanner.
package dot_scan_ctrl_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 16;
  localparam logic [7:0] ROW_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  // Row 0 is the top row and maps to the MSB of the active-low select.
  function automatic logic [7:0] row_sel(input logic [2:0] idx);
    return ~(8'h80 >> idx);
  endfunction

endpackage

// File: rtl/dot_frame_buf.sv
// Two 8x16 image banks: one registered write port, one combinational
// read port, both addressed by bank select and row.
module dot_frame_buf
  import dot_scan_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_bank,
  input  logic [2:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            rd_bank,
  input  logic [2:0]      rd_row,
  output logic [COLS-1:0] rd_data
);

  logic [COLS-1:0] mem [2][ROWS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_row] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_row];

endmodule

// File: rtl/dot_scan_ctrl.sv
// Row-scan scheduler: steps 8 rows with a blanking lead-in per row and
// swaps display/back banks only at frame boundaries.
module dot_scan_ctrl
  import dot_scan_ctrl_pkg::*;
#(
  parameter int DIV       = 2500,
  parameter int BLANK_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_done,
  output logic [7:0]      row,
  output logic [COLS-1:0] col
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

  logic [CW-1:0]   cnt;
  logic [2:0]      rc;
  logic            active;
  logic            pending;
  logic            frame_end;
  logic [COLS-1:0] rd_data;
  scan_state_t     state;

  always_comb begin
    state = IDLE;
    if (enable) begin
      state = (cnt < CNT_SHOW) ? BLANK : SHOW;
    end
  end

  assign frame_end = enable && (rc == 3'd7) && (cnt == CNT_LAST);

  // Producers always write the bank not being displayed.
  dot_frame_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_bank (~active),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_bank (active),
    .rd_row  (rc),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      rc  <= '0;
    end else if (!enable) begin
      cnt <= '0;
      rc  <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      rc  <= rc + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= ROW_OFF;
      col <= '0;
    end else begin
      case (state)
        SHOW: begin
          row <= row_sel(rc);
          col <= rd_data;
        end
        default: begin
          row <= ROW_OFF;
          col <= '0;
        end
      endcase
    end
  end

  // A request landing in the frame-end cycle itself is honoured at that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active     <= 1'b0;
      pending    <= 1'b0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end && (pending || swap_req)) begin
        active   <= ~active;
        pending  <= 1'b0;
        swap_ack <= 1'b1;
      end else begin
        swap_ack <= 1'b0;
        if (swap_req) begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// Scoreboarded bench for dot_scan_ctrl: a cycle model queues expected
// outputs per driven cycle; each scenario task pops and compares them.
module tb_dot_scan_ctrl;

  localparam int DIV   = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [15:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        frame_done;
  logic [7:0]  row;
  logic [15:0] col;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  row;
    logic [15:0] col;
    logic        fd;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] m_bank [2][8];
  logic        m_act;
  logic        m_pend;
  int          m_cnt;
  int          m_rc;

  dot_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_done (frame_done),
    .row        (row),
    .col        (col)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        m_bank[b][r] = '0;
    m_act  = 1'b0;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_rc   = 0;
  endtask

  // Drives one cycle of stimulus, queues the model's expected outputs for the
  // following edge, advances the model, then waits until just after that edge.
  task automatic drive(input logic en, input logic we, input logic [2:0] wr,
                       input logic [15:0] wd, input logic sr);
    exp_t e;
    logic fe;
    enable   = en;
    wr_en    = we;
    wr_row   = wr;
    wr_data  = wd;
    swap_req = sr;
    if (en && m_cnt >= BLANK) begin
      e.row = ~(8'h80 >> m_rc);
      e.col = m_bank[m_act][m_rc];
    end else begin
      e.row = 8'hFF;
      e.col = 16'h0000;
    end
    fe    = en && (m_rc == 7) && (m_cnt == DIV - 1);
    e.fd  = fe;
    e.ack = fe && (m_pend || sr);
    if (we) m_bank[!m_act][wr] = wd;
    if (e.ack) begin
      m_act  = !m_act;
      m_pend = 1'b0;
    end else if (sr) begin
      m_pend = 1'b1;
    end
    if (!en) begin
      m_cnt = 0;
      m_rc  = 0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_rc  = (m_rc + 1) % 8;
    end else begin
      m_cnt++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total++;
    if (row !== 8'hFF || col !== 16'h0 || frame_done !== 1'b0 || swap_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_async got row=%h col=%h fd=%b ack=%b want FF/0000/0/0", row, col, frame_done, swap_ack);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (row !== 8'hFF || col !== 16'h0 || frame_done !== 1'b0 || swap_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_held got row=%h col=%h fd=%b ack=%b want FF/0000/0/0", row, col, frame_done, swap_ack);
    end
    rst = 1'b1;
  endtask

  task automatic test_first_frame();
    exp_t e;
    int acks = 0;
    int c;
    for (int r = 0; r < 9; r++) begin
      if (r < 8) drive(1'b0, 1'b1, 3'(r), 16'h0001 << r, 1'b0);
      else       drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL first_idle got %h/%h/%b/%b want %h/%h/%b/%b", row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL first_scan i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
      if (swap_ack === 1'b1) acks++;
      if (i == FRAME - 1) begin
        total++;
        if (swap_ack !== 1'b1 || frame_done !== 1'b1) begin
          bad++;
          $display("[TB] FAIL first_ack got ack=%b fd=%b want 1/1", swap_ack, frame_done);
        end
      end
      if (i >= FRAME + 3 * DIV && i < FRAME + 4 * DIV) begin
        c = i - (FRAME + 3 * DIV);
        total++;
        if (c < BLANK ? (row !== 8'hFF || col !== 16'h0) : (row !== 8'b11101111 || col !== 16'h0008)) begin
          bad++;
          $display("[TB] FAIL first_row3 cnt=%0d got row=%h col=%h", c, row, col);
        end
      end
    end
    total++;
    if (acks != 1) begin
      bad++;
      $display("[TB] FAIL first_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_steady();
    exp_t e;
    logic [7:0] seq[$];
    logic [7:0] want [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] prev = 8'hFF;
    int fds = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL steady i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
      if (frame_done === 1'b1) begin
        fds++;
        total++;
        if (i % FRAME != FRAME - 1) begin
          bad++;
          $display("[TB] FAIL steady_fd_pos got i=%0d want i%%80=79", i);
        end
      end
      if (row !== 8'hFF && prev === 8'hFF) seq.push_back(row);
      prev = row;
    end
    total++;
    if (fds != 2 || seq.size() != 16) begin
      bad++;
      $display("[TB] FAIL steady_counts got fd=%0d rows=%0d want 2/16", fds, seq.size());
    end
    for (int k = 0; k < 8 && k < seq.size(); k++) begin
      total++;
      if (seq[k] !== want[k]) begin
        bad++;
        $display("[TB] FAIL steady_rowseq k=%0d got %h want %h", k, seq[k], want[k]);
      end
    end
  endtask

  task automatic test_swap_merge();
    exp_t e;
    int acks = 0;
    for (int i = 0; i < FRAME; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, (i == 5 || i == 20 || i == 40));
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL merge i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
      if (swap_ack === 1'b1) acks++;
    end
    total++;
    if (acks != 1 || swap_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL merge_ack_count got %0d last=%b want 1/1", acks, swap_ack);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic edge_cyc;
    int c;
    for (int i = 0; i < 2 * FRAME; i++) begin
      edge_cyc = (i == FRAME - 1);
      drive(1'b1, edge_cyc, 3'd5, 16'hFFFF, edge_cyc);
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL b2b i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
      if (edge_cyc) begin
        total++;
        if (swap_ack !== 1'b1 || frame_done !== 1'b1) begin
          bad++;
          $display("[TB] FAIL b2b_coincident got ack=%b fd=%b want 1/1", swap_ack, frame_done);
        end
      end
      if (i >= FRAME + 5 * DIV + BLANK && i < FRAME + 6 * DIV) begin
        c = i - (FRAME + 5 * DIV);
        total++;
        if (row !== 8'hFB || col !== 16'hFFFF) begin
          bad++;
          $display("[TB] FAIL b2b_row5 cnt=%0d got row=%h col=%h want FB/FFFF", c, row, col);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    int fds = 0;
    for (int i = 0; i < 4 * DIV + 6 + 4 + 20; i++) begin
      logic en;
      en = !(i >= 4 * DIV + 6 && i < 4 * DIV + 10);
      drive(en, 1'b0, 3'd0, 16'h0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL endrop i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
      if (frame_done === 1'b1) fds++;
      if (i == 4 * DIV + 6) begin
        total++;
        if (row !== 8'hFF || col !== 16'h0) begin
          bad++;
          $display("[TB] FAIL endrop_blank got row=%h col=%h want FF/0000", row, col);
        end
      end
      if (i >= 4 * DIV + 10 && i < 4 * DIV + 13) begin
        total++;
        if (row !== ((i == 4 * DIV + 12) ? 8'h7F : 8'hFF)) begin
          bad++;
          $display("[TB] FAIL endrop_restart k=%0d got row=%h", i - (4 * DIV + 10), row);
        end
      end
    end
    total++;
    if (fds != 0) begin
      bad++;
      $display("[TB] FAIL endrop_fd got %0d want 0", fds);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int acks = 0;
    int nz = 0;
    for (int i = 0; i < 2 * DIV + 5; i++) begin
      drive(1'b1, 1'b1, 3'(i % 8), 16'hA5A5, (i == 3));
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL rstmid_pre i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (row !== 8'hFF || col !== 16'h0 || swap_ack !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_async got row=%h col=%h fd=%b ack=%b want FF/0000/0/0", row, col, frame_done, swap_ack);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < FRAME + DIV; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({row, col, frame_done, swap_ack} !== {e.row, e.col, e.fd, e.ack}) begin
        bad++;
        $display("[TB] FAIL rstmid_post i=%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, row, col, frame_done, swap_ack, e.row, e.col, e.fd, e.ack);
      end
      if (swap_ack === 1'b1) acks++;
      if (col !== 16'h0) nz++;
    end
    total++;
    if (acks != 0 || nz != 0) begin
      bad++;
      $display("[TB] FAIL rstmid_clean got acks=%0d nonzero_col=%0d want 0/0", acks, nz);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_frame();
    test_steady();
    test_swap_merge();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
